multiplier_acc: RTL and testbench

//   Sequential shift-add multiply-accumulate: product = multiplicand*multiplier + addend.

---
 rtl/multiplier_acc_if.sv | 33 +++
 rtl/multiplier_acc.sv | 80 ++++++++
 tb/tb_multiplier_acc.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_acc_if.sv
// rtl/multiplier_acc_if.sv - start/ready handshake bundle for the shift-add multiply-accumulator
//
// Signals:
//   start        request, accepted only while ready=1
//   multiplicand operand A (N bits), sampled on accept
//   multiplier   operand B (N bits), sampled on accept
//   addend       operand C (N bits, zero-extended), sampled on accept
//   product      A*B+C (2N bits), valid while ready=1 after a completed run
//   ready        1 = idle, product stable
//   done         one-cycle pulse on the cycle ready returns to 1
// Modports: master drives the request side, slave is the multiplier.

interface multiplier_acc_if #(
    parameter int N = 32
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic [N-1:0]     addend;
    logic [2*N-1:0]   product;
    logic             ready;
    logic             done;

    modport master (
        output start, multiplicand, multiplier, addend,
        input  product, ready, done
    );

    modport slave (
        input  start, multiplicand, multiplier, addend,
        output product, ready, done
    );
endinterface

// File: rtl/multiplier_acc.sv
// rtl/multiplier_acc.sv - sequential shift-add multiply-accumulate, product = A*B + C
//
// One partial product per clock. Also serves as the inverse of the column
// divider: quotient*divider + remainder rebuilds the dividend.
//
// Ports:
//   clk  in   system clock, all logic on posedge
//   rst  in   synchronous active-high reset, overrides start
//   bus  slave modport of multiplier_acc_if (start/operands in, product/ready/done out)
//
// Optional feature macro: MULT_EARLY_EXIT_EN
//   defined   - a run ends on the busy cycle after which no multiplier bits remain set
//   undefined - every run takes exactly N busy cycles

module multiplier_acc #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    multiplier_acc_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic           r_done;

    logic           w_ready;
    logic           w_accept;
    logic [N-1:0]   w_mplier_next;
    logic           w_last;

    assign w_ready       = (r_cnt == '0);
    assign w_accept      = w_ready && bus.start;
    assign w_mplier_next = r_mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
    // Once the shifted multiplier is empty no further partial products can be
    // added, so this busy cycle is the last one regardless of the count.
    assign w_last = (r_cnt == CW'(1)) || (w_mplier_next == '0);
`else
    assign w_last = (r_cnt == CW'(1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_acc    <= {{N{1'b0}}, bus.addend};
                r_mcand  <= {{N{1'b0}}, bus.multiplicand};
                r_mplier <= bus.multiplier;
                r_cnt    <= CW'(N);
            end else if (!w_ready) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= w_mplier_next;
                if (w_last) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt - CW'(1);
                end
            end
        end
    end

    assign bus.product = r_acc;
    assign bus.ready   = w_ready;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_multiplier_acc.sv
// tb/tb_multiplier_acc.sv - randomized and directed self-checking bench for multiplier_acc

module tb_multiplier_acc;
    localparam int N = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   model_live;

    multiplier_acc_if #(.N(N)) bus ();

    multiplier_acc #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected run length for a given multiplier value.
    function automatic int lat_of(input logic [N-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < N; i++) if (b[i]) msb = i;
        return (msb < 0) ? 1 : msb + 1;
`else
        return N;
`endif
    endfunction

    function automatic logic [2*N-1:0] mac(input logic [N-1:0] a, b, c);
        logic [2*N-1:0] wa, wb, wc;
        wa = {{N{1'b0}}, a};
        wb = {{N{1'b0}}, b};
        wc = {{N{1'b0}}, c};
        return wa * wb + wc;
    endfunction

    task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is "remaining cycles" plus the arithmetic result.
    int             m_rem;
    logic [2*N-1:0] m_prod;
    logic [2*N-1:0] m_pend;
    logic           m_done;

    always @(posedge clk) begin
        model_live <= 1'b1;
        if (rst) begin
            m_rem  <= 0;
            m_prod <= '0;
            m_pend <= '0;
            m_done <= 1'b0;
        end else if (m_rem == 0 && bus.start) begin
            m_rem  <= lat_of(bus.multiplier);
            m_pend <= mac(bus.multiplicand, bus.multiplier, bus.addend);
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) m_prod <= m_pend;
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("ready", {{(2*N-1){1'b0}}, bus.ready}, {{(2*N-1){1'b0}}, (m_rem == 0)});
            chk("done",  {{(2*N-1){1'b0}}, bus.done},  {{(2*N-1){1'b0}}, m_done});
            if (m_rem == 0) chk("product", bus.product, m_prod);
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!bus.ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [N-1:0] a, b, c, output int lat, output logic [2*N-1:0] p);
        wait_ready();
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.addend       = c;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.ready && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) chk("run_timeout", 0, 1);
        p = bus.product;
    endtask

    initial begin
        int             lat;
        int             c1, c2, cyc;
        logic [2*N-1:0] p;
        logic [N-1:0]   a, b, c;

        total = 0;
        bad   = 0;
        model_live = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.addend       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_ready",   {63'd0, bus.ready}, 64'd1);
        chk("reset_done",    {63'd0, bus.done},  64'd0);
        chk("reset_product", bus.product,        64'd0);

        do_op(32'd7, 32'd6, 32'd5, lat, p);
        chk("a7b6c5_product", p, 64'h0000_0000_0000_002F);
`ifdef MULT_EARLY_EXIT_EN
        chk("a7b6c5_latency", 64'(lat), 64'd3);
`else
        chk("a7b6c5_latency", 64'(lat), 64'd32);
`endif

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p);
        chk("all_ones_product", p, 64'hFFFF_FFFF_0000_0000);
        chk("all_ones_latency", 64'(lat), 64'd32);

        do_op(32'd3, 32'd10, 32'd4, lat, p);
        chk("divider_crosscheck", p, 64'h22);

        do_op(32'd0, 32'd1234, 32'd77, lat, p);
        chk("mcand_zero", p, 64'd77);
        do_op(32'd999, 32'd0, 32'd55, lat, p);
        chk("mplier_zero", p, 64'd55);
`ifdef MULT_EARLY_EXIT_EN
        chk("mplier_zero_latency", 64'(lat), 64'd1);
`else
        chk("mplier_zero_latency", 64'(lat), 64'd32);
`endif

        // start while busy is ignored
        wait_ready();
        bus.start = 1'b1; bus.multiplicand = 32'd2; bus.multiplier = 32'hC000_0003; bus.addend = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.multiplicand = 32'd9; bus.multiplier = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_ready();
        chk("busy_start_ignored", bus.product, mac(32'd2, 32'hC000_0003, 32'd0));

        // reset mid-run
        wait_ready();
        bus.start = 1'b1; bus.multiplicand = 32'd2; bus.multiplier = 32'hFFFF_FFFF; bus.addend = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_rst_ready",   {63'd0, bus.ready}, 64'd1);
        chk("midrun_rst_product", bus.product,        64'd0);
        chk("midrun_rst_done",    {63'd0, bus.done},  64'd0);
        do_op(32'd1, 32'd1, 32'd1, lat, p);
        chk("after_rst_product", p, 64'd2);

        // start held high across two runs
        wait_ready();
        bus.start = 1'b1; bus.multiplicand = 32'd4; bus.multiplier = 32'd4; bus.addend = 32'd0;
        @(posedge clk); #1;
        bus.multiplicand = 32'd5; bus.multiplier = 32'd5; bus.addend = 32'd1;
        c1 = -1; c2 = -1; cyc = 0;
        while (c2 < 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done) begin
                if (c1 < 0) begin
                    c1 = cyc;
                    chk("held_first_product", bus.product, 64'd16);
                end else begin
                    c2 = cyc;
                    bus.start = 1'b0;
                    chk("held_second_product", bus.product, 64'd26);
                end
            end
        end
        bus.start = 1'b0;
        if (c2 < 0) chk("held_timeout", 0, 1);
`ifdef MULT_EARLY_EXIT_EN
        chk("held_done_spacing", 64'(c2 - c1), 64'd4);
`else
        chk("held_done_spacing", 64'(c2 - c1), 64'd33);
`endif

        do_op(32'd5, 32'd3, 32'd0, lat, p);
        chk("early_product", p, 64'd15);
`ifdef MULT_EARLY_EXIT_EN
        chk("early_latency", 64'(lat), 64'd2);
`else
        chk("early_latency", 64'(lat), 64'd32);
`endif

        // randomized runs
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            c = $urandom;
            if (i % 4 == 1) b = b >> $urandom_range(N - 1, 0);
            if (i % 7 == 3) a = '0;
            do_op(a, b, c, lat, p);
            chk("rand_product", p, mac(a, b, c));
            chk("rand_latency", 64'(lat), 64'(lat_of(b)));
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
            chk("rand_hold", bus.product, mac(a, b, c));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
